// File: rtl/eif_mon_pkg.sv
`default_nettype none
// ============================================================================
// Package  : eif_mon_pkg
// Brief    : Shared constants, event type and helpers for the EIF spike
//            monitor. The event layout carries a peak field only when
//            EIF_MON_PEAK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package eif_mon_pkg;

    localparam int c_isi_w_def      = 8;
    localparam int c_window_len_def = 256;
    localparam int c_fifo_depth     = 2;

    // Event at the default ISI width; the top rebuilds the same layout at
    // its configured ISI width and hands that to the FIFO.
    typedef struct packed {
        logic [c_isi_w_def-1:0] isi;
        logic                   first;
`ifdef EIF_MON_PEAK_EN
        logic [7:0]             peak;
`endif
    } eif_evt_t;

    // Saturating 8-bit increment used by the spike-rate counters
    function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
        if (inc && (v != 8'hFF)) begin
            return v + 8'd1;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eif_mon_fifo.sv
`default_nettype none
// ============================================================================
// Module   : eif_mon_fifo
// Brief    : Small valid/ready event FIFO. A push while full is accepted
//            when a pop happens in the same cycle. Head is read straight
//            from storage so it stays stable until popped.
// Revision : 1.0 - initial release
// ============================================================================
module eif_mon_fifo
    import eif_mon_pkg::*;
#(
    parameter type T     = eif_evt_t,
    parameter int  DEPTH = c_fifo_depth
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_head,
    output logic o_full,
    output logic o_empty
);

    // Pointers wrap naturally, so DEPTH must be a power of two
    localparam int                 c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    T                   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_pop;
    logic               w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_depth);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy; pop frees a slot before the push lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/eif_spike_monitor.sv
`default_nettype none
// ============================================================================
// Module   : eif_spike_monitor
// Brief    : Monitors a neuron spike line. Each rising edge produces an
//            event {ISI, first-flag, peak state} into a 2-entry FIFO, and a
//            windowed spike rate is published every WINDOW_LEN enabled
//            cycles. Dropped events set a sticky overflow flag.
// Config   : EIF_MON_PEAK_EN - track max(state_i) per ISI into each event;
//            when undefined evt_peak_o is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module eif_spike_monitor
    import eif_mon_pkg::*;
#(
    parameter int WINDOW_LEN = c_window_len_def,
    parameter int ISI_W      = c_isi_w_def
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             spike_i,
    input  logic [7:0]       state_i,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [ISI_W-1:0] evt_isi_o,
    output logic             evt_first_o,
    output logic [7:0]       evt_peak_o,
    output logic [7:0]       rate_o,
    output logic             rate_stb_o,
    output logic             ovf_o
);

    localparam int                 c_win_w    = $clog2(WINDOW_LEN);
    localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WINDOW_LEN - 1);

    typedef struct packed {
        logic [ISI_W-1:0] isi;
        logic             first;
`ifdef EIF_MON_PEAK_EN
        logic [7:0]       peak;
`endif
    } evt_t;

    logic               r_spike_d;
    logic [ISI_W-1:0]   r_isi;
    logic               r_first_armed;
    logic [c_win_w-1:0] r_win;
    logic [7:0]         r_spk_cnt;
    logic               w_edge;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    evt_t               w_evt;
    evt_t               w_head;

    assign w_edge      = ena & spike_i & ~r_spike_d;
    assign evt_valid_o = ~w_empty;
    assign w_pop       = evt_valid_o & evt_ready_i;

    assign w_evt.isi   = r_isi;
    assign w_evt.first = r_first_armed;
    assign evt_isi_o   = w_head.isi;
    assign evt_first_o = w_head.first;

`ifdef EIF_MON_PEAK_EN
    logic [7:0] r_peak;
    logic [7:0] w_peak_now;

    // Peak so far in this ISI, including the current cycle
    assign w_peak_now = (state_i > r_peak) ? state_i : r_peak;
    assign w_evt.peak = w_peak_now;
    assign evt_peak_o = w_head.peak;

    // Running maximum; restarts from the edge-cycle state after every edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak <= '0;
        end else if (ena) begin
            r_peak <= w_edge ? state_i : w_peak_now;
        end
    end
`else
    // Membrane state is only needed for peak tracking
    logic w_unused_state;
    assign w_unused_state = ^state_i;
    assign evt_peak_o     = 8'h00;
`endif

    // Edge history, saturating ISI counter, first-event flag and drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spike_d     <= 1'b0;
            r_isi         <= '0;
            r_first_armed <= 1'b1;
            ovf_o         <= 1'b0;
        end else begin
            r_spike_d <= spike_i;
            if (ena) begin
                if (w_edge) begin
                    r_isi <= ISI_W'(1);
                end else if (r_isi != '1) begin
                    r_isi <= r_isi + ISI_W'(1);
                end
            end
            if (w_edge) begin
                r_first_armed <= 1'b0;
            end
            if (w_edge && w_full && !w_pop) begin
                ovf_o <= 1'b1;
            end
        end
    end

    // Rate window: publish the edge count (incl. a last-cycle edge) and restart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win      <= '0;
            r_spk_cnt  <= '0;
            rate_o     <= '0;
            rate_stb_o <= 1'b0;
        end else begin
            rate_stb_o <= 1'b0;
            if (ena) begin
                r_win <= r_win + c_win_w'(1);
                if (r_win == c_win_last) begin
                    rate_o     <= sat_inc8(r_spk_cnt, w_edge);
                    rate_stb_o <= 1'b1;
                    r_spk_cnt  <= '0;
                end else begin
                    r_spk_cnt <= sat_inc8(r_spk_cnt, w_edge);
                end
            end
        end
    end

    eif_mon_fifo #(
        .T     (evt_t),
        .DEPTH (c_fifo_depth)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_edge),
        .i_data  (w_evt),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_eif_spike_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_eif_spike_monitor
// Brief    : Self-checking bench for eif_spike_monitor with a queue-based
//            reference model, directed scenarios and randomized traffic.
// Config   : EIF_MON_PEAK_EN - selects the expected peak behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eif_spike_monitor;

    localparam int c_wl      = 16;
    localparam int c_iw      = 8;
    localparam int c_isi_max = (1 << c_iw) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ena = 1'b0;
    logic            spike_i = 1'b0;
    logic [7:0]      state_i = 8'd0;
    logic            evt_ready_i = 1'b0;
    logic            evt_valid_o;
    logic [c_iw-1:0] evt_isi_o;
    logic            evt_first_o;
    logic [7:0]      evt_peak_o;
    logic [7:0]      rate_o;
    logic            rate_stb_o;
    logic            ovf_o;

    eif_spike_monitor #(
        .WINDOW_LEN (c_wl),
        .ISI_W      (c_iw)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .spike_i     (spike_i),
        .state_i     (state_i),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_isi_o   (evt_isi_o),
        .evt_first_o (evt_first_o),
        .evt_peak_o  (evt_peak_o),
        .rate_o      (rate_o),
        .rate_stb_o  (rate_stb_o),
        .ovf_o       (ovf_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int isi;
        int first;
        int peak;
    } ev_t;

    ev_t m_q[$];
    int  m_states[$];   // enabled-cycle states since the last edge
    int  m_k;           // enabled cycles since reset
    int  m_last_idx;    // enabled-cycle index of the last edge
    int  m_win_edges;
    int  m_rate;
    bit  m_prev;
    bit  m_first;
    bit  m_ovf;
    bit  m_stb;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_states.delete();
        m_k         = 0;
        m_last_idx  = 0;
        m_win_edges = 0;
        m_rate      = 0;
        m_prev      = 1'b0;
        m_first     = 1'b1;
        m_ovf       = 1'b0;
        m_stb       = 1'b0;
    endtask

    task automatic model_step(input bit sp, input bit en, input bit rdy, input int st);
        bit  edge_now;
        int  mx;
        ev_t ev;
        edge_now = en && sp && !m_prev;
        m_prev   = sp;
        if (m_q.size() != 0 && rdy) begin
            void'(m_q.pop_front());
        end
        m_stb = 1'b0;
        if (en) begin
            m_states.push_back(st);
        end
        if (edge_now) begin
            mx = 0;
            foreach (m_states[i]) begin
                if (m_states[i] > mx) mx = m_states[i];
            end
            ev.isi   = (m_k - m_last_idx > c_isi_max) ? c_isi_max : (m_k - m_last_idx);
            ev.first = m_first ? 1 : 0;
`ifdef EIF_MON_PEAK_EN
            ev.peak  = mx;
`else
            ev.peak  = 0;
`endif
            m_first    = 1'b0;
            m_last_idx = m_k;
            m_states.delete();
            m_states.push_back(st);
            if (m_q.size() < 2) m_q.push_back(ev);
            else                m_ovf = 1'b1;
            m_win_edges++;
        end
        if (en) begin
            if ((m_k % c_wl) == c_wl - 1) begin
                m_rate      = (m_win_edges > 255) ? 255 : m_win_edges;
                m_stb       = 1'b1;
                m_win_edges = 0;
            end
            m_k++;
        end
    endtask

    task automatic compare_all();
        check_eq("valid", evt_valid_o, m_q.size() != 0);
        if (m_q.size() != 0) begin
            check_eq("isi", evt_isi_o, m_q[0].isi);
            check_eq("first", evt_first_o, m_q[0].first);
            check_eq("peak", evt_peak_o, m_q[0].peak);
        end
        check_eq("rate", rate_o, m_rate);
        check_eq("rate_stb", rate_stb_o, m_stb);
        check_eq("ovf", ovf_o, m_ovf);
    endtask

    // One clock: drive at negedge, predict, sample just after the rising edge
    task automatic step(input bit sp, input bit en, input bit rdy, input int st);
        @(negedge clk);
        spike_i     = sp;
        ena         = en;
        evt_ready_i = rdy;
        state_i     = 8'(st);
        model_step(sp, en, rdy, st);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, rdy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        spike_i     = 1'b0;
        ena         = 1'b0;
        evt_ready_i = 1'b0;
        state_i     = 8'd0;
        #1;
        model_reset();
        check_eq("rst_valid", evt_valid_o, 0);
        check_eq("rst_isi", evt_isi_o, 0);
        check_eq("rst_first", evt_first_o, 0);
        check_eq("rst_peak", evt_peak_o, 0);
        check_eq("rst_rate", rate_o, 0);
        check_eq("rst_stb", rate_stb_o, 0);
        check_eq("rst_ovf", ovf_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int stb_seen;
        int valid_seen;
        int exp_peak;

        model_reset();
        do_reset();

        // Edges at cycles 10 and 35 with ready held high
        for (int c = 0; c <= 35; c++) begin
            step((c == 10) || (c == 35), 1'b1, 1'b1, 0);
            if (c == 10) begin
                check_eq("dir_first_valid", evt_valid_o, 1);
                check_eq("dir_first_flag", evt_first_o, 1);
            end
        end
        check_eq("dir_isi25", evt_isi_o, 25);
        check_eq("dir_second_first", evt_first_o, 0);
        idle(3, 1'b1);

        // Spike held high for 5 cycles yields one event
        valid_seen = 0;
        for (int c = 0; c < 10; c++) begin
            step(c < 5, 1'b1, 1'b1, 0);
            if (evt_valid_o) valid_seen++;
        end
        check_eq("held_one_event", valid_seen, 1);

        // 300-cycle gap saturates the ISI
        idle(300, 1'b1);
        step(1'b1, 1'b1, 1'b1, 0);
        check_eq("isi_sat", evt_isi_o, 255);
        idle(1, 1'b1);

        // Ready low: two retained, third dropped, then drain in order
        idle(4, 1'b0);
        step(1'b1, 1'b1, 1'b0, 0);      // ISI 6
        idle(3, 1'b0);
        step(1'b1, 1'b1, 1'b0, 0);      // ISI 4
        idle(2, 1'b0);
        step(1'b1, 1'b1, 1'b0, 0);      // ISI 3, dropped
        check_eq("ovf_set", ovf_o, 1);
        check_eq("full_head_isi", evt_isi_o, 6);
        step(1'b0, 1'b1, 1'b1, 0);
        check_eq("drain_valid2", evt_valid_o, 1);
        check_eq("drain_isi2", evt_isi_o, 4);
        step(1'b0, 1'b1, 1'b1, 0);
        check_eq("drain_empty", evt_valid_o, 0);
        check_eq("ovf_sticky", ovf_o, 1);

        // Window of 16 with 4 edges, one on the last cycle
        do_reset();
        stb_seen = 0;
        for (int c = 0; c < c_wl; c++) begin
            step((c == 2) || (c == 6) || (c == 10) || (c == 15), 1'b1, 1'b1, 0);
            if (rate_stb_o) stb_seen++;
        end
        check_eq("win_rate", rate_o, 4);
        check_eq("win_stb", rate_stb_o, 1);
        step(1'b0, 1'b1, 1'b1, 0);
        if (rate_stb_o) stb_seen++;
        check_eq("win_stb_count", stb_seen, 1);

        // Reset with a pending event, then first flag re-armed
        idle(2, 1'b0);
        step(1'b1, 1'b1, 1'b0, 0);
        idle(1, 1'b0);
        check_eq("pending_valid", evt_valid_o, 1);
        do_reset();
        idle(3, 1'b1);
        step(1'b1, 1'b1, 1'b1, 0);
        check_eq("rearm_first", evt_first_o, 1);

        // Peak: ramp to 90, fall to 20, then spike
        do_reset();
        for (int v = 0; v <= 90; v++) step(1'b0, 1'b1, 1'b1, v);
        idle(0, 1'b1);
        for (int c = 0; c < 5; c++) step(1'b0, 1'b1, 1'b1, 20);
        step(1'b1, 1'b1, 1'b1, 20);
`ifdef EIF_MON_PEAK_EN
        exp_peak = 90;
`else
        exp_peak = 0;
`endif
        check_eq("peak_ramp", evt_peak_o, exp_peak);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
            end
            step($urandom_range(0, 2) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eif_spike_monitor.md
EIF_SPIKE_MONITOR -- requirements
Module: eif_spike_monitor

Interface
REQ-001 Parameter WINDOW_LEN, default 256: rate-window length in clock cycles, power of two, range 16..4096.
REQ-002 Parameter ISI_W, default 8: inter-spike-interval (ISI) counter width in bits.
REQ-003 Port clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port ena, input, 1: when low, counters and FIFO hold their values and spike edges are ignored.
REQ-006 Port spike_i, input, 1: neuron spike line, synchronous to clk; may stay high for more than one cycle.
REQ-007 Port state_i, input, 8: neuron membrane state, unsigned.
REQ-008 Port evt_valid_o, output, 1: FIFO head holds an event.
REQ-009 Port evt_ready_i, input, 1: consumer accepts the head event.
REQ-010 Port evt_isi_o, output, ISI_W: ISI of the head event.
REQ-011 Port evt_first_o, output, 1: head event is the first spike since reset, so its ISI is meaningless.
REQ-012 Port evt_peak_o, output, 8: peak state_i within the ISI of the head event.
REQ-013 Port rate_o, output, 8: number of spikes counted in the last completed window.
REQ-014 Port rate_stb_o, output, 1: one-cycle pulse when rate_o updates.
REQ-015 Port ovf_o, output, 1: sticky flag, set when an event is dropped.

Function
REQ-016 A spike edge is spike_i high on a cycle where it was low on the previous cycle, sampled while ena is high; a held-high spike yields exactly one edge.
REQ-017 The ISI counter increments every enabled cycle and saturates at 2^ISI_W-1.
- On an edge cycle, the counter value is captured, then the counter loads 1 on the next cycle.
REQ-018 On an edge cycle, the event {isi, first, peak} is pushed into a 2-entry FIFO; evt_valid_o rises the cycle after the edge (latency 1).
REQ-019 The FIFO pops on any cycle with evt_valid_o and evt_ready_i both high.
- Push and pop in the same cycle while full: the pop completes first and the push succeeds.
- evt_* outputs stay stable while evt_valid_o is high and evt_ready_i is low.
REQ-020 Edge while the FIFO is full and no pop occurs that cycle: the event is dropped and ovf_o is set; ovf_o clears only on reset.
REQ-021 evt_first_o is 1 for the first edge after reset and 0 for every later edge.
REQ-022 The window counter counts enabled cycles modulo WINDOW_LEN, and the spike counter counts edges, saturating at 255.
- On the last cycle of a window, rate_o loads the spike count, including an edge occurring on that same cycle.
- rate_stb_o pulses for that one cycle, and the spike counter restarts at 0.
REQ-023 Outputs evt_* and rate_o are registered; there are no combinational paths from inputs to outputs except evt_valid_o gating from FIFO state.

Reset
REQ-024 While rst_n is low, the following values are forced:
- all outputs 0;
- ISI counter 0;
- window counter 0;
- FIFO empty;
- first-flag armed.
REQ-025 Reset mid-handshake discards any pending events without emitting a pop; after release, the first edge has evt_first_o=1.

Configuration
REQ-026 Macro EIF_MON_PEAK_EN, when defined, adds a peak register.
- The register tracks max(state_i) over each ISI, including the edge cycle.
- It is captured into the event and restarts from the current state_i after each edge.
REQ-027 Without EIF_MON_PEAK_EN, evt_peak_o is constant 0 and no peak storage exists in the FIFO.

Structure
REQ-028 Package eif_mon_pkg holds:
- the default ISI_W and WINDOW_LEN constants;
- the FIFO depth constant (2);
- typedef eif_evt_t {isi, first, peak}.
REQ-029 Sub-module eif_mon_fifo is the 2-entry valid/ready FIFO of eif_evt_t, with full/empty outputs.

Verification
REQ-030 Reset release, spike edges at cycles 10 and 35, evt_ready_i held 1:
- first event has evt_first_o=1;
- second event has evt_isi_o=25 and evt_first_o=0.
REQ-031 spike_i held high for 5 cycles: exactly one event.
REQ-032 Gap of 300 cycles between spikes with ISI_W=8: evt_isi_o=255.
REQ-033 evt_ready_i held 0 with 3 edges:
- 2 events retained;
- ovf_o=1 after the 3rd edge;
- raising ready drains exactly 2 events in order.
REQ-034 WINDOW_LEN=16 with 4 edges in the window, one on its last cycle: rate_o=4 with a single rate_stb_o pulse.
REQ-035 With EIF_MON_PEAK_EN defined, state_i ramp 0..90 then falling to 20 before a spike: evt_peak_o=90; without the macro, evt_peak_o=0.
